// File: rtl/train_stop_sequencer_pkg.sv
// Shared state encoding, output table and timed-state successor map
// for the train stop sequencer.
package train_pkg;

  localparam int TW_DEFAULT = 19;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_WARN   = 4'd1,
    S_ACCEL  = 4'd2,
    S_CRUISE = 4'd3,
    S_BRAKE  = 4'd4,
    S_DOPEN  = 4'd5,
    S_DWELL  = 4'd6,
    S_DCLOSE = 4'd7,
    S_EMERG  = 4'd8
  } state_e;

  typedef struct packed {
    logic motor;
    logic brake;
    logic door;
    logic lamp;
  } outs_t;

  function automatic outs_t stateOutputs(input state_e s);
    case (s)
      S_IDLE:   return '{motor: 1'b0, brake: 1'b1, door: 1'b0, lamp: 1'b0};
      S_WARN:   return '{motor: 1'b0, brake: 1'b1, door: 1'b0, lamp: 1'b1};
      S_ACCEL:  return '{motor: 1'b1, brake: 1'b0, door: 1'b0, lamp: 1'b0};
      S_CRUISE: return '{motor: 1'b1, brake: 1'b0, door: 1'b0, lamp: 1'b0};
      S_BRAKE:  return '{motor: 1'b0, brake: 1'b1, door: 1'b0, lamp: 1'b0};
      S_DOPEN:  return '{motor: 1'b0, brake: 1'b1, door: 1'b1, lamp: 1'b0};
      S_DWELL:  return '{motor: 1'b0, brake: 1'b1, door: 1'b1, lamp: 1'b0};
      S_DCLOSE: return '{motor: 1'b0, brake: 1'b1, door: 1'b1, lamp: 1'b0};
      default:  return '{motor: 1'b0, brake: 1'b1, door: 1'b0, lamp: 1'b1};
    endcase
  endfunction

  // Where each timed state goes when its countdown expires; cruise expiry is a fault.
  function automatic state_e timedNext(input state_e s);
    case (s)
      S_WARN:   return S_ACCEL;
      S_ACCEL:  return S_CRUISE;
      S_BRAKE:  return S_DOPEN;
      S_DOPEN:  return S_DWELL;
      S_DWELL:  return S_DCLOSE;
      S_DCLOSE: return S_IDLE;
      default:  return S_EMERG;
    endcase
  endfunction

endpackage

// File: rtl/train_stop_sequencer_countdown_timer.sv
// Loadable down-counter that saturates at zero; done flags an empty count.
module countdown_timer #(
  parameter int TW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done,
  output logic [TW-1:0] count
);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - TW'(1);
    end
  end

  assign count = count_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/train_stop_sequencer.sv
// Station-to-station sequencer for one train: Moore FSM with registered
// outputs, driving a shared countdown timer that is reloaded on every state entry.
module train_stop_sequencer
  import train_pkg::*;
#(
  parameter int TW        = TW_DEFAULT,
  parameter int WARN_T    = 50,
  parameter int ACCEL_T   = 200,
  parameter int CRUISE_MX = 4000,
  parameter int BRAKE_T   = 150,
  parameter int DOOR_T    = 40,
  parameter int DWELL_T   = 300,
  parameter int EMERG_T   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop_req,
  input  logic       station_sensor,
  input  logic       door_obstruct,
  output logic       motor_en,
  output logic       brake,
  output logic       door_open,
  output logic       warn_lamp,
  output logic       fault,
  output logic [3:0] present_state
);

  state_e        state_q, state_d;
  logic          fault_q, fault_d;
  logic          startPrev_q;
  outs_t         outs_q;
  logic          tmrLoad;
  logic [TW-1:0] tmrLoadVal;
  logic          tmrDone;
  logic [TW-1:0] unusedTmrCount;

  // A state lasting D cycles loads D-1 so that done rises on its last cycle.
  function automatic logic [TW-1:0] loadValue(input int d);
    return (d <= 1) ? '0 : TW'(d - 1);
  endfunction

  function automatic logic [TW-1:0] durationFor(input state_e s);
    case (s)
      S_WARN:   return loadValue(WARN_T);
      S_ACCEL:  return loadValue(ACCEL_T);
      S_CRUISE: return loadValue(CRUISE_MX);
      S_BRAKE:  return loadValue(BRAKE_T);
      S_DOPEN:  return loadValue(DOOR_T);
      S_DWELL:  return loadValue(DWELL_T);
      S_DCLOSE: return loadValue(DOOR_T);
      S_EMERG:  return loadValue(EMERG_T);
      default:  return '0;
    endcase
  endfunction

  countdown_timer #(.TW(TW)) uTimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmrLoad),
    .load_val (tmrLoadVal),
    .done     (tmrDone),
    .count    (unusedTmrCount)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (start && !startPrev_q) begin
          state_d = S_WARN;
          fault_d = 1'b0;
        end
      end
      S_EMERG: begin
        if (tmrDone && !stop_req) state_d = S_IDLE;
      end
      S_WARN, S_ACCEL, S_CRUISE, S_BRAKE, S_DOPEN, S_DWELL, S_DCLOSE: begin
        if (stop_req) begin
          state_d = S_EMERG;
        end else if (state_q == S_DCLOSE && door_obstruct) begin
          state_d = S_DOPEN;
        end else if (state_q == S_CRUISE && station_sensor) begin
          state_d = S_BRAKE;
        end else if (tmrDone) begin
          state_d = timedNext(state_q);
          if (state_q == S_CRUISE) fault_d = 1'b1;
        end
      end
      default: state_d = S_EMERG;
    endcase
    tmrLoad    = (state_d != state_q);
    tmrLoadVal = durationFor(state_d);
  end

  // startPrev_q resets high so a start held through reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fault_q     <= 1'b0;
      startPrev_q <= 1'b1;
      outs_q      <= stateOutputs(S_IDLE);
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      startPrev_q <= start;
      outs_q      <= stateOutputs(state_d);
    end
  end

  assign motor_en      = outs_q.motor;
  assign brake         = outs_q.brake;
  assign door_open     = outs_q.door;
  assign warn_lamp     = outs_q.lamp;
  assign fault         = fault_q;
  assign present_state = state_q;

endmodule

// File: tb/tb_train_stop_sequencer.sv
// Scoreboard bench: each test queues the expected state runs (state, length,
// fault) and a negedge monitor closes a run whenever present_state changes.
`timescale 1ns/1ps
module tb_train_stop_sequencer;

  typedef struct {
    logic [3:0] st;
    int         len;
    logic       flt;
  } run_t;

  run_t sbQ[$];
  int   total = 0;
  int   bad   = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop_req = 1'b0;
  logic       station_sensor = 1'b0;
  logic       door_obstruct = 1'b0;
  logic       motor_en, brake, door_open, warn_lamp, fault;
  logic [3:0] present_state;

  logic       start0 = 1'b0;
  logic       motor0, brake0, door0, lamp0, fault0;
  logic [3:0] state0;

  always #5 clk = ~clk;

  train_stop_sequencer #(
    .TW(19), .WARN_T(3), .ACCEL_T(2), .CRUISE_MX(10), .BRAKE_T(2),
    .DOOR_T(2), .DWELL_T(4), .EMERG_T(3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop_req       (stop_req),
    .station_sensor (station_sensor),
    .door_obstruct  (door_obstruct),
    .motor_en       (motor_en),
    .brake          (brake),
    .door_open      (door_open),
    .warn_lamp      (warn_lamp),
    .fault          (fault),
    .present_state  (present_state)
  );

  // Second copy with a zero-length warning phase.
  train_stop_sequencer #(
    .TW(19), .WARN_T(0), .ACCEL_T(2), .CRUISE_MX(10), .BRAKE_T(2),
    .DOOR_T(2), .DWELL_T(4), .EMERG_T(3)
  ) dutZero (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start0),
    .stop_req       (1'b0),
    .station_sensor (1'b0),
    .door_obstruct  (1'b0),
    .motor_en       (motor0),
    .brake          (brake0),
    .door_open      (door0),
    .warn_lamp      (lamp0),
    .fault          (fault0),
    .present_state  (state0)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sr, input logic ss, input logic dob);
    start          = st;
    stop_req       = sr;
    station_sensor = ss;
    door_obstruct  = dob;
  endtask

  task automatic pushRun(input logic [3:0] st, input int len, input logic flt);
    run_t e;
    e.st  = st;
    e.len = len;
    e.flt = flt;
    sbQ.push_back(e);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitState(input logic [3:0] s, input int budget);
    int n = 0;
    @(negedge clk);
    while (present_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("wait_state%0d", s), present_state, s);
  endtask

  // Motor, brake, door, lamp for each state code.
  function automatic int expOut(input logic [3:0] s);
    case (s)
      4'd0: return 4'b0100;
      4'd1: return 4'b0101;
      4'd2: return 4'b1000;
      4'd3: return 4'b1000;
      4'd4: return 4'b0100;
      4'd5: return 4'b0110;
      4'd6: return 4'b0110;
      4'd7: return 4'b0110;
      4'd8: return 4'b0101;
      default: return 4'b1111;
    endcase
  endfunction

  logic       monOn = 1'b0;
  logic       runActive = 1'b0;
  logic [3:0] curSt = 4'd0;
  int         curLen = 0;
  logic       curFlt = 1'b0;

  task automatic finishRun();
    run_t e;
    if (sbQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpected_run: state=%0d len=%0d with empty scoreboard", curSt, curLen);
    end else begin
      e = sbQ.pop_front();
      checkOutput($sformatf("run_state(exp %0d)", e.st), curSt, e.st);
      if (e.len != 0) checkOutput($sformatf("run_len(state %0d)", e.st), curLen, e.len);
      checkOutput($sformatf("run_fault(state %0d)", e.st), curFlt, e.flt);
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("outputs", {motor_en, brake, door_open, warn_lamp}, expOut(present_state));
      if (!runActive) begin
        curSt     = present_state;
        curLen    = 1;
        runActive = 1'b1;
      end else if (present_state != curSt) begin
        finishRun();
        curSt  = present_state;
        curLen = 1;
      end else begin
        curLen++;
      end
      curFlt = fault;
    end
  end

  initial begin
    #100000;
    bad++;
    $display("[TB] FAIL watchdog: time limit reached, state=%0d", present_state);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_state", present_state, 0);
    checkOutput("rst_brake", brake, 1);
    checkOutput("rst_motor", motor_en, 0);
    checkOutput("rst_door", door_open, 0);
    checkOutput("rst_lamp", warn_lamp, 0);
    checkOutput("rst_fault", fault, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pushRun(4'd0, 0, 1'b0);
    monOn = 1'b1;
    repeat (2) @(negedge clk);

    // Normal cycle, station marker on the 5th cruise cycle.
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 2, 1'b0); pushRun(4'd3, 5, 1'b0);
    pushRun(4'd4, 2, 1'b0); pushRun(4'd5, 2, 1'b0); pushRun(4'd6, 4, 1'b0);
    pushRun(4'd7, 2, 1'b0); pushRun(4'd0, 0, 1'b0);
    pulseStart();
    waitState(4'd3, 20);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd0, 40);
    repeat (2) @(negedge clk);

    // Door obstruction on the first closing cycle reopens the doors.
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 2, 1'b0); pushRun(4'd3, 3, 1'b0);
    pushRun(4'd4, 2, 1'b0); pushRun(4'd5, 2, 1'b0); pushRun(4'd6, 4, 1'b0);
    pushRun(4'd7, 1, 1'b0); pushRun(4'd5, 2, 1'b0); pushRun(4'd6, 4, 1'b0);
    pushRun(4'd7, 2, 1'b0); pushRun(4'd0, 0, 1'b0);
    pulseStart();
    waitState(4'd3, 20);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd7, 40);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd0, 60);
    repeat (2) @(negedge clk);

    // Cruise timeout: fault sticks through idle.
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 2, 1'b0); pushRun(4'd3, 10, 1'b0);
    pushRun(4'd8, 3, 1'b1); pushRun(4'd0, 0, 1'b1);
    pulseStart();
    waitState(4'd8, 40);
    waitState(4'd0, 20);
    repeat (2) @(negedge clk);

    // Emergency hold: stop_req for 6 cycles from the first accel cycle; fault cleared by start.
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 1, 1'b0); pushRun(4'd8, 6, 1'b0);
    pushRun(4'd0, 0, 1'b0);
    pulseStart();
    waitState(4'd2, 20);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd0, 20);
    repeat (2) @(negedge clk);

    // stop_req beats station_sensor in cruise.
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 2, 1'b0); pushRun(4'd3, 2, 1'b0);
    pushRun(4'd8, 3, 1'b0); pushRun(4'd0, 0, 1'b0);
    pulseStart();
    waitState(4'd3, 20);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd0, 30);
    repeat (2) @(negedge clk);

    // Station marker on the expiry cycle wins: brake, no fault.
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 2, 1'b0); pushRun(4'd3, 10, 1'b0);
    pushRun(4'd4, 2, 1'b0); pushRun(4'd5, 2, 1'b0); pushRun(4'd6, 4, 1'b0);
    pushRun(4'd7, 2, 1'b0); pushRun(4'd0, 0, 1'b0);
    pulseStart();
    waitState(4'd3, 20);
    repeat (9) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd0, 40);
    repeat (2) @(negedge clk);

    // Zero-length warning lasts exactly one cycle.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    checkOutput("d0_warn_state", state0, 1);
    checkOutput("d0_warn_lamp", lamp0, 1);
    @(negedge clk);
    checkOutput("d0_accel_state", state0, 2);

    // Asynchronous reset in the dwell, then start held through release.
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 2, 1'b0); pushRun(4'd3, 1, 1'b0);
    pushRun(4'd4, 2, 1'b0); pushRun(4'd5, 2, 1'b0); pushRun(4'd6, 2, 1'b0);
    pushRun(4'd0, 0, 1'b0);
    pushRun(4'd1, 3, 1'b0); pushRun(4'd2, 2, 1'b0); pushRun(4'd3, 2, 1'b0);
    pushRun(4'd4, 2, 1'b0); pushRun(4'd5, 2, 1'b0); pushRun(4'd6, 4, 1'b0);
    pushRun(4'd7, 2, 1'b0); pushRun(4'd0, 0, 1'b0);
    pulseStart();
    waitState(4'd3, 20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd6, 30);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_brake", brake, 1);
    checkOutput("async_door", door_open, 0);
    checkOutput("async_state", present_state, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("held_start_idle", present_state, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulseStart();
    waitState(4'd3, 20);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitState(4'd0, 40);
    repeat (3) @(negedge clk);

    checkOutput("sb_pending", sbQ.size(), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
